// File: rtl/fetch_unit.sv
// IF-stage sequencer: fetches from instruction memory over req/ack, hands {instr, pc}
// to IF/ID over valid/ready, and applies ID redirects after one delay slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redir_valid,
  input  logic [1:0]  redir_sel,
  input  logic [31:0] beq_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc8,
  output logic        align_err
);

  typedef enum logic {S_FETCH, S_FULL} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pendTarget;
  logic        pendValid;
  logic [31:0] selTarget;
  logic [31:0] npc;
  logic        handover;
  logic        takeRedir;

  always_comb begin
    selTarget = jr_target;
    case (redir_sel)
      2'b01:   selTarget = beq_target;
      2'b10:   selTarget = jump_target;
      default: selTarget = jr_target;
    endcase
  end

  // pc already points at the delay slot when a redirect is pended, so the
  // pending target is consumed by the ack of the following fetch.
  assign npc       = pendValid ? pendTarget : pc + 32'd4;
  assign handover  = (state == S_FULL) && if_ready;
  assign takeRedir = handover && redir_valid && (redir_sel != 2'b00);
  assign im_addr   = pc;
  assign if_pc8    = if_pc + 32'd8;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      im_req     <= 1'b0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      pendValid  <= 1'b0;
      pendTarget <= '0;
      align_err  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          // im_req is a register so reset clears it asynchronously; it rises
          // on the first edge after release.
          if (!im_req) begin
            im_req <= 1'b1;
          end else if (im_ack) begin
            im_req    <= 1'b0;
            if_instr  <= im_rdata;
            if_pc     <= pc;
            if_valid  <= 1'b1;
            pc        <= npc;
            pendValid <= 1'b0;
            state     <= S_FULL;
          end
        end
        S_FULL: begin
          if (handover) begin
            if_valid <= 1'b0;
            im_req   <= 1'b1;
            state    <= S_FETCH;
          end
          if (takeRedir) begin
            pendValid  <= 1'b1;
            pendTarget <= {selTarget[31:2], 2'b00};
            if (selTarget[1:0] != 2'b00) align_err <= 1'b1;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: program-order reference model of the
// delivered {pc, instr} stream with one-delay-slot redirects, plus directed timing checks.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_sel = 2'b00;
  logic [31:0] beq_target = '0, jump_target = '0, jr_target = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr, if_pc, if_pc8;
  logic        align_err;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redir_valid(redir_valid), .redir_sel(redir_sel),
    .beq_target(beq_target), .jump_target(jump_target), .jr_target(jr_target),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc8(if_pc8), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ae;
  } exp_t;

  exp_t        expQ[$];
  int          nChecks = 0;
  int          nFail = 0;
  int          readyPct = 100;
  int          redirPct = 0;
  int          fixedWait = 0;
  logic [31:0] modelPc;
  logic        prvValid;
  logic [31:0] prvTarget;
  logic        modelAe;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (!ok) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] randTarget();
    int r;
    r = $urandom_range(0, 39);
    if (r == 0) return 32'hFFFF_FFFC;
    if (r == 1) return 32'h3000 + $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
    return 32'h3000 + $urandom_range(0, 1023) * 4;
  endfunction

  task automatic modelReset();
    expQ.delete();
    modelPc  = RESET_PC;
    prvValid = 1'b0;
    prvTarget = '0;
    modelAe  = 1'b0;
    expQ.push_back('{RESET_PC, memFn(RESET_PC), 1'b0});
  endtask

  // ID side: random ready/redirect; each handover pushes the next program-order instruction.
  initial begin
    forever begin
      @(negedge clk);
      if_ready    = ($urandom_range(0, 99) < readyPct);
      redir_valid = ($urandom_range(0, 99) < redirPct);
      redir_sel   = 2'($urandom_range(0, 3));
      beq_target  = randTarget();
      jump_target = randTarget();
      jr_target   = randTarget();
      if (reset && if_valid && if_ready) begin
        logic [31:0] nxt, tgt;
        logic take;
        nxt  = prvValid ? prvTarget : modelPc + 32'd4;
        take = redir_valid && (redir_sel != 2'b00);
        tgt  = (redir_sel == 2'b01) ? beq_target : (redir_sel == 2'b10) ? jump_target : jr_target;
        if (take && tgt[1:0] != 2'b00) modelAe = 1'b1;
        prvValid  = take;
        prvTarget = {tgt[31:2], 2'b00};
        expQ.push_back('{nxt, memFn(nxt), modelAe});
        modelPc = nxt;
      end
    end
  end

  // Instruction memory with configurable or random ack latency.
  initial begin
    bit busy = 0;
    int waitN = 0;
    logic [31:0] reqAddr = '0;
    forever begin
      @(negedge clk);
      im_ack = 1'b0;
      if (!reset) busy = 0;
      else if (im_req) begin
        if (!busy) begin
          busy = 1;
          waitN = (fixedWait >= 0) ? fixedWait : $urandom_range(0, 3);
          reqAddr = im_addr;
        end else check(im_addr == reqAddr, "im_addr_stable", im_addr, reqAddr);
        if (waitN == 0) begin
          im_ack = 1'b1;
          im_rdata = memFn(im_addr);
          busy = 0;
        end else waitN--;
      end
    end
  end

  // Monitor: compares each newly presented instruction against the scoreboard.
  initial begin
    bit lastV = 0;
    int idle = 0;
    exp_t cur = '{32'h0, 32'h0, 1'b0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        lastV = 0;
        idle = 0;
      end else begin
        if (if_valid && !lastV) begin
          if (expQ.size() == 0) check(1'b0, "unexpected_delivery", if_pc, 32'h0);
          else begin
            cur = expQ.pop_front();
            check(if_pc == cur.pc, "if_pc", if_pc, cur.pc);
            check(if_instr == cur.instr, "if_instr", if_instr, cur.instr);
            check(if_pc8 == cur.pc + 32'd8, "if_pc8", if_pc8, cur.pc + 32'd8);
            check(align_err == cur.ae, "align_err", {31'b0, align_err}, {31'b0, cur.ae});
          end
          idle = 0;
        end else if (if_valid) begin
          check(if_pc == cur.pc && if_instr == cur.instr, "stall_hold", if_pc, cur.pc);
          check(im_req == 1'b0, "stall_no_req", {31'b0, im_req}, 32'h0);
        end else if (expQ.size() > 0) begin
          idle++;
          if (idle > 100) begin
            check(1'b0, "delivery_timeout", 32'(idle), 32'd100);
            idle = 0;
          end
        end
        lastV = if_valid;
      end
    end
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check(im_req == 1'b0, "rst_im_req", {31'b0, im_req}, 32'h0);
    check(if_valid == 1'b0, "rst_if_valid", {31'b0, if_valid}, 32'h0);
    check(if_pc == 32'h0, "rst_if_pc", if_pc, 32'h0);
    check(if_instr == 32'h0, "rst_if_instr", if_instr, 32'h0);
    check(align_err == 1'b0, "rst_align_err", {31'b0, align_err}, 32'h0);
    modelReset();
    reset = 1'b1;

    // Zero-wait memory, always ready: alternate-cycle fetches.
    @(posedge clk); #2;
    check(im_req && im_addr == 32'h3000, "fetch0_addr", im_addr, 32'h3000);
    @(posedge clk); #2;
    check(!im_req && if_valid && if_pc == 32'h3000, "deliver0_pc", if_pc, 32'h3000);
    check(if_pc8 == 32'h3008, "deliver0_pc8", if_pc8, 32'h3008);
    @(posedge clk); #2;
    check(im_req && im_addr == 32'h3004, "fetch1_addr", im_addr, 32'h3004);

    // 3-cycle ack delay on the 3004 fetch.
    fixedWait = 3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check(im_req && im_addr == 32'h3004 && !if_valid, "wait_hold", im_addr, 32'h3004);
    end
    @(posedge clk); #2;
    check(if_valid && if_pc == 32'h3004, "late_ack_valid", if_pc, 32'h3004);

    // 5-cycle stall.
    readyPct = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check(if_valid && !im_req && if_pc == 32'h3004, "stall5", if_pc, 32'h3004);
    end
    readyPct = 70;
    redirPct = 50;
    fixedWait = -1;
    repeat (1500) @(posedge clk);

    // Asynchronous reset mid-fetch.
    begin
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(posedge clk); #2;
        if (im_req) seen = 1;
      end
      check(seen, "mid_fetch_found", {31'b0, seen}, 32'h1);
    end
    reset = 1'b0;
    #1;
    check(im_req == 1'b0, "async_req_drop", {31'b0, im_req}, 32'h0);
    check(if_valid == 1'b0 && align_err == 1'b0, "async_clear", {31'b0, if_valid}, 32'h0);
    modelReset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    check(im_req && im_addr == RESET_PC, "post_reset_addr", im_addr, RESET_PC);
    repeat (1500) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
